// File: rtl/instruction_fetch_sequencer.sv
// Instruction fetch sequencer.
// Reads four bytes per instruction from a byte-wide, combinational-read
// instruction memory (big-endian: byte at PC lands in [31:24]), assembles
// the word and hands it to decode over a valid/ready handshake. Owns the
// fetch PC: sequential +4, redirect, and sticky address-fault detection.
//
// Ports:
//   clk_i, rst_n_i          clock (rising edge), async active-low reset
//   fetch_en_i              permit starting a new fetch
//   redirect_valid_i/pc_i   load a new PC, flush the in-flight fetch
//   mem_addr_o / mem_byte_i byte address out, same-cycle read data in
//   instr_o, instr_pc_o     assembled instruction and its address
//   instr_valid_o/ready_i   handshake towards decode
//   pc_o                    next address to be fetched
//   fault_o                 sticky misaligned / out-of-range flag
module instruction_fetch_sequencer #(
    parameter int                PCSize               = 32,
    parameter int                InstructionSize      = 32,
    parameter int                AmountOfInstructions = 128,
    parameter logic [PCSize-1:0] ResetPC              = '0
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       fetch_en_i,
    input  logic                       redirect_valid_i,
    input  logic [PCSize-1:0]          redirect_pc_i,
    output logic [PCSize-1:0]          mem_addr_o,
    input  logic [7:0]                 mem_byte_i,
    output logic [InstructionSize-1:0] instr_o,
    output logic [PCSize-1:0]          instr_pc_o,
    output logic                       instr_valid_o,
    input  logic                       instr_ready_i,
    output logic [PCSize-1:0]          pc_o,
    output logic                       fault_o
);

    typedef enum logic [1:0] {IDLE, FETCH, VALID, FAULT} state_e;

    state_e                     state_q, state_d;
    logic [PCSize-1:0]          pc_q, pc_d;
    logic [1:0]                 cnt_q, cnt_d;
    // Upper three bytes of the word; the last byte goes straight to instr.
    logic [InstructionSize-9:0] buf_q, buf_d;
    logic [InstructionSize-1:0] instr_q, instr_d;
    logic [PCSize-1:0]          instr_pc_q, instr_pc_d;
    logic                       valid_q, valid_d;
    logic                       fault_q, fault_d;

    // Word must be aligned and its last byte inside memory. One extra bit
    // keeps pc+3 from wrapping around to a small, seemingly valid address.
    function automatic logic addr_ok(input logic [PCSize-1:0] a);
        logic [PCSize:0] last;
        last = {1'b0, a} + (PCSize+1)'(3);
        return (a[1:0] == 2'b00) && (last < (PCSize+1)'(AmountOfInstructions));
    endfunction

    assign mem_addr_o    = (state_q == FETCH) ? pc_q + PCSize'(cnt_q) : pc_q;
    assign instr_o       = instr_q;
    assign instr_pc_o    = instr_pc_q;
    assign instr_valid_o = valid_q;
    assign pc_o          = pc_q;
    assign fault_o       = fault_q;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        cnt_d      = cnt_q;
        buf_d      = buf_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;
        fault_d    = fault_q;

        if (redirect_valid_i) begin
            // Overrides everything, including a word completing this cycle.
            // A VALID word with ready high is taken by decode on this same
            // edge, so dropping valid here loses nothing.
            pc_d    = redirect_pc_i;
            cnt_d   = '0;
            buf_d   = '0;
            valid_d = 1'b0;
            fault_d = 1'b0;
            if (!fetch_en_i) begin
                state_d = IDLE;
            end else if (addr_ok(redirect_pc_i)) begin
                state_d = FETCH;
            end else begin
                state_d = FAULT;
                fault_d = 1'b1;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (fetch_en_i) begin
                        cnt_d = '0;
                        if (addr_ok(pc_q)) begin
                            state_d = FETCH;
                        end else begin
                            state_d = FAULT;
                            fault_d = 1'b1;
                        end
                    end
                end
                FETCH: begin
                    cnt_d = cnt_q + 2'd1;
                    unique case (cnt_q)
                        2'd0: buf_d[23:16] = mem_byte_i;
                        2'd1: buf_d[15:8]  = mem_byte_i;
                        2'd2: buf_d[7:0]   = mem_byte_i;
                        default: begin
                            instr_d    = {buf_q, mem_byte_i};
                            instr_pc_d = pc_q;
                            pc_d       = pc_q + PCSize'(4);
                            valid_d    = 1'b1;
                            state_d    = VALID;
                        end
                    endcase
                end
                VALID: begin
                    if (instr_ready_i) begin
                        valid_d = 1'b0;
                        if (!fetch_en_i) begin
                            state_d = IDLE;
                        end else if (addr_ok(pc_q)) begin
                            state_d = FETCH;
                            cnt_d   = '0;
                        end else begin
                            state_d = FAULT;
                            fault_d = 1'b1;
                        end
                    end
                end
                default: begin
                    // FAULT: parked until redirect or reset.
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            pc_q       <= ResetPC;
            cnt_q      <= '0;
            buf_q      <= '0;
            instr_q    <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            cnt_q      <= cnt_d;
            buf_q      <= buf_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
            fault_q    <= fault_d;
        end
    end

endmodule

// File: doc/instruction_fetch_sequencer.md
Name: instruction_fetch_sequencer

Overview:
- Drives the byte-wide, combinational-read instruction memory, which stores one byte per entry with instructions big-endian: the byte at PC is [31:24] and the byte at PC+3 is [7:0].
- Issues four byte reads per instruction and assembles the 32-bit word.
- Presents the word to decode over a valid/ready handshake.
- Owns the architectural fetch PC, including sequential increment, redirect (branch/jump) and address-fault detection.
- Sits between the PC/branch logic and the decode stage.

Parameters:
- PCSize, 32, width of all address/PC signals.
- InstructionSize, 32, assembled instruction width; fixed at 4 bytes.
- AmountOfInstructions, 128, memory depth in bytes; valid byte addresses are 0..AmountOfInstructions-1.
- ResetPC, 0, PC value loaded on reset.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- fetch_en  input  1  permits starting a new instruction fetch.
- redirect_valid  input  1  load redirect_pc; flush the in-flight fetch.
- redirect_pc  input  PCSize  redirect target.
- mem_addr  output  PCSize  byte address to the instruction memory (combinational).
- mem_byte  input  8  read data for mem_addr, valid in the same cycle.
- instr  output  InstructionSize  assembled instruction (registered).
- instr_pc  output  PCSize  address of instr (registered).
- instr_valid  output  1  instr/instr_pc are valid.
- instr_ready  input  1  decode accepts instr this cycle.
- pc  output  PCSize  next address to be fetched.
- fault  output  1  sticky flag: misaligned or out-of-range fetch address.

Behaviour:
- Clocking and reset: one clock domain. Asynchronous active-low reset takes effect immediately. Reset values:
  - state=IDLE, pc=ResetPC, cnt=0, assembly buffer=0.
  - instr=0, instr_pc=0, instr_valid=0, fault=0.
  - Reset mid-fetch discards all partial bytes.
- States: IDLE, FETCH (2-bit byte counter cnt), VALID, FAULT.
- mem_addr = pc + cnt in FETCH; mem_addr = pc in all other states. Arithmetic is modulo 2^PCSize.
- IDLE:
  - if fetch_en=1, run the address check (below).
  - Check passes -> FETCH with cnt=0.
  - Check fails -> FAULT with fault<=1.
- Address check: pc[1:0]!=0, or pc+3 >= AmountOfInstructions (computed at PCSize+1 bits so no wrap) -> fail.
- FETCH: each cycle, mem_byte is captured into buffer byte (3-cnt), i.e. cnt0 -> [31:24] ... cnt3 -> [7:0], and cnt increments.
  - On the cnt=3 edge: instr<={buffer[31:8], mem_byte}, instr_pc<=pc, pc<=pc+4, instr_valid<=1, cnt<=0, state -> VALID.
  - Latency: instr_valid rises on the 4th rising edge after the first FETCH cycle, so a fetch takes exactly 4 FETCH cycles.
- fetch_en deasserted during FETCH does not abort; the current instruction completes.
- VALID:
  - Holds instr, instr_pc and instr_valid stable until instr_ready=1.
  - On handshake: instr_valid<=0, then the address check on pc. Pass with fetch_en=1 -> FETCH. fetch_en=0 -> IDLE. Fail with fetch_en=1 -> FAULT.
  - Throughput: one instruction per 5 cycles with ready held high.
- FAULT: fault=1, no memory reads (mem_addr=pc), instr_valid=0. Exits only by redirect or reset.
- Redirect (highest priority, any state):
  - pc<=redirect_pc, cnt<=0, buffer discarded, instr_valid<=0, fault<=0.
  - Next state: FETCH if fetch_en=1 and redirect_pc passes the check; FAULT if fetch_en=1 and it fails; IDLE otherwise.
  - In VALID with instr_ready=1 in the same cycle, the transfer counts as completed (decode consumed it) before the flush.
  - In FETCH at cnt=3, the completing instruction is dropped: no instr_valid, no pc+4.
- No combinational path from instr_ready or redirect_valid to any output except through registers. mem_addr depends only on state registers.

Test Plan:
- Reset with ResetPC=0, memory bytes 0..3 = 0x12,0x34,0x56,0x78, fetch_en=1, instr_ready=1 -> mem_addr 0,1,2,3 on consecutive cycles; instr=0x12345678, instr_pc=0, instr_valid high 4 edges after the first FETCH cycle, pc=4.
- Back-pressure: instr_ready=0 for 10 cycles after valid -> instr, instr_pc and instr_valid stable, mem_addr held at 4; ready=1 -> next fetch at 4..7, second instr=bytes 4..7, instr_pc=4.
- Redirect at FETCH cnt=2 to 0x20 -> partial word discarded, no instr_valid, next mem_addr=0x20, assembled instr_pc=0x20.
- Redirect in VALID with instr_ready=1 in the same cycle -> one transfer counted; next fetch from the redirect target; pc+4 path not used.
- With AmountOfInstructions=128, sequential fetch reaching pc=124 -> fetch of 124..127 completes; at pc=128, fault=1 and state FAULT with no reads; redirect to 0 -> fault=0, fetch resumes at 0. Redirect to 0x06 -> fault=1 (misaligned).
- Assert rst_n low mid-FETCH (cnt=1) -> all outputs at reset values immediately, without waiting for a clock edge; after release, fetch restarts at ResetPC.
